// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Combinational only; no latency or flow control of its own.
package bcd_pkg;

  localparam int DIGITOS_DEF = 4;
  localparam logic [3:0] BCD_MAX_DIGITO = 4'd9;
  localparam logic [3:0] CORRECCION = 4'd3;

  typedef enum logic [1:0] {
    INACTIVO     = 2'd0,
    CONVIRTIENDO = 2'd1,
    HECHO        = 2'd2
  } estado_conv_t;

  // Smallest width w with 2**w >= 10**digitos, i.e. ceil(log2(10**digitos)).
  function automatic int ancho_bin(input int digitos);
    longint unsigned potencia;
    int ancho;
    potencia = 1;
    ancho = 0;
    for (int i = 0; i < digitos; i++) potencia = potencia * 10;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < potencia) ancho = i + 1;
    end
    return ancho;
  endfunction

endpackage

// File: rtl/bcd_corrector_digito.sv
// One reverse double-dabble digit step: subtract 3 when the shifted digit is >= 8.
// Purely combinational, zero latency, no backpressure.
module bcd_corrector_digito
  import bcd_pkg::*;
(
  input  logic [3:0] digito,
  output logic [3:0] corregido
);

  assign corregido = (digito >= 4'd8) ? (digito - CORRECCION) : digito;

endmodule

// File: rtl/bcd_a_binario.sv
// Iterative BCD-to-binary converter, one bit per clock (valido ANCHO_BIN+2 edges after accept, 2 on bad digit).
// Backpressure: inicio is only taken while listo=1; requests while busy are dropped, not queued.
module bcd_a_binario
  import bcd_pkg::*;
#(
  parameter int DIGITOS   = DIGITOS_DEF,
  parameter int ANCHO_BIN = ancho_bin(DIGITOS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [4*DIGITOS-1:0]   bcd_entrada,
  output logic                   listo,
  output logic                   valido,
  output logic [ANCHO_BIN-1:0]   binario,
  output logic                   error_bcd
);

  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  estado_conv_t          estado, estado_sig;
  logic [ANCHO_BCD-1:0]  reg_bcd;
  logic [ANCHO_BCD-1:0]  bcd_desplazado;
  logic [ANCHO_BCD-1:0]  bcd_corregido;
  logic [ANCHO_BIN-1:0]  reg_bin;
  logic [ANCHO_CNT-1:0]  contador;
  logic                  error_reg;
  logic [DIGITOS-1:0]    digito_invalido;

  assign bcd_desplazado = reg_bcd >> 1;

  for (genvar i = 0; i < DIGITOS; i++) begin : g_digito
    bcd_corrector_digito u_corrector (
      .digito    (bcd_desplazado[4*i +: 4]),
      .corregido (bcd_corregido[4*i +: 4])
    );
    // Codes 10..15 all have bit 3 set plus bit 2 or bit 1.
    assign digito_invalido[i] = bcd_entrada[4*i+3] & (bcd_entrada[4*i+2] | bcd_entrada[4*i+1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= INACTIVO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    listo      = 1'b0;
    case (estado)
      INACTIVO: begin
        listo = 1'b1;
        if (inicio) estado_sig = (|digito_invalido) ? HECHO : CONVIRTIENDO;
      end
      CONVIRTIENDO: begin
        if (contador == ANCHO_CNT'(1)) estado_sig = HECHO;
      end
      HECHO:   estado_sig = INACTIVO;
      default: estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_bcd   <= '0;
      reg_bin   <= '0;
      contador  <= '0;
      error_reg <= 1'b0;
      valido    <= 1'b0;
      binario   <= '0;
      error_bcd <= 1'b0;
    end else begin
      valido <= 1'b0;
      case (estado)
        INACTIVO: begin
          if (inicio) begin
            reg_bcd   <= bcd_entrada;
            reg_bin   <= '0;
            contador  <= ANCHO_CNT'(ANCHO_BIN);
            error_reg <= |digito_invalido;
          end
        end
        CONVIRTIENDO: begin
          reg_bcd  <= bcd_corregido;
          reg_bin  <= {reg_bcd[0], reg_bin[ANCHO_BIN-1:1]};
          contador <= contador - ANCHO_CNT'(1);
        end
        HECHO: begin
          valido    <= 1'b1;
          binario   <= error_reg ? '0 : reg_bin;
          error_bcd <= error_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_a_binario.sv
// Directed bench for bcd_a_binario: vector table, sampled sweep against a decimal model,
// and hand-written back-to-back, ignored-request and mid-conversion reset sequences.
module tb_bcd_a_binario;

  localparam int DIG   = 4;
  localparam int ANCHO = 14;

  logic             clk;
  logic             rst_n;
  logic             inicio;
  logic [4*DIG-1:0] bcd_entrada;
  logic             listo;
  logic             valido;
  logic [ANCHO-1:0] binario;
  logic             error_bcd;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vector_t;

  vector_t tabla[14];

  bcd_a_binario #(.DIGITOS(DIG), .ANCHO_BIN(ANCHO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inicio      (inicio),
    .bcd_entrada (bcd_entrada),
    .listo       (listo),
    .valido      (valido),
    .binario     (binario),
    .error_bcd   (error_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nombre, input logic [63:0] act, input logic [63:0] esp);
    checks++;
    if (act !== esp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nombre, act, esp);
    end
  endtask

  // Every valid result must leave the BCD register fully drained.
  always @(posedge clk) begin
    #1;
    if (rst_n && valido && !error_bcd) begin
      checks++;
      assert (dut.reg_bcd == '0)
      else begin
        failures++;
        $display("FAIL reg_bcd_drained: got %0h expected 0", dut.reg_bcd);
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle; returns #1 after the valido edge.
  task automatic convertir(input logic [15:0] bcd, input logic [13:0] exp_bin,
                           input logic exp_err, input int pulso, input string nombre);
    int  n;
    bit  visto;
    bit  listo_mal;
    int  lat_esp;
    lat_esp   = exp_err ? 1 : ANCHO + 1;
    n         = 0;
    visto     = 1'b0;
    listo_mal = 1'b0;
    check({nombre, "_listo_previo"}, 64'(listo), 64'd1);
    inicio      = 1'b1;
    bcd_entrada = bcd;
    @(posedge clk); #1;
    inicio      = 1'b0;
    bcd_entrada = 16'hDEAD;
    while (n < 40) begin
      if (pulso != 0 && n == pulso) begin
        inicio      = 1'b1;
        bcd_entrada = 16'h0777;
      end else if (pulso != 0 && n == pulso + 1) begin
        inicio = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (valido) begin
        visto = 1'b1;
        break;
      end
      if (listo) listo_mal = 1'b1;
    end
    inicio = 1'b0;
    check({nombre, "_latencia"}, visto ? 64'(n) : 64'hFFFF, 64'(lat_esp));
    check({nombre, "_binario"}, 64'(binario), 64'(exp_bin));
    check({nombre, "_error"}, 64'(error_bcd), 64'(exp_err));
    if (!exp_err) check({nombre, "_listo_ocupado"}, 64'(listo_mal), 64'd0);
  endtask

  initial begin
    int n;
    int vistos;
    logic [15:0] bcd_v;

    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    inicio      = 1'b0;
    bcd_entrada = '0;

    tabla[0]  = '{16'h0000, 14'd0,    1'b0};
    tabla[1]  = '{16'h1998, 14'd1998, 1'b0};
    tabla[2]  = '{16'h9999, 14'd9999, 1'b0};
    tabla[3]  = '{16'h0001, 14'd1,    1'b0};
    tabla[4]  = '{16'h12A4, 14'd0,    1'b1};
    tabla[5]  = '{16'h0042, 14'd42,   1'b0};
    tabla[6]  = '{16'h0009, 14'd9,    1'b0};
    tabla[7]  = '{16'h9000, 14'd9000, 1'b0};
    tabla[8]  = '{16'h0080, 14'd80,   1'b0};
    tabla[9]  = '{16'h000A, 14'd0,    1'b1};
    tabla[10] = '{16'h5050, 14'd5050, 1'b0};
    tabla[11] = '{16'hF000, 14'd0,    1'b1};
    tabla[12] = '{16'h0B00, 14'd0,    1'b1};
    tabla[13] = '{16'h8765, 14'd8765, 1'b0};

    #2;
    check("reset_listo",  64'(listo),     64'd1);
    check("reset_valido", 64'(valido),    64'd0);
    check("reset_binario", 64'(binario),  64'd0);
    check("reset_error",  64'(error_bcd), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      convertir(tabla[i].bcd, tabla[i].bin, tabla[i].err, 0, $sformatf("tabla%0d", i));

    // Back-to-back: inicio held across the first conversion.
    inicio      = 1'b1;
    bcd_entrada = 16'h9999;
    @(posedge clk); #1;
    bcd_entrada = 16'h0001;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (valido) break;
    end
    check("b2b_lat1", 64'(n), 64'(ANCHO + 1));
    check("b2b_bin1", 64'(binario), 64'd9999);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check("b2b_aceptado", 64'(listo), 64'd0);
        inicio = 1'b0;
      end
      if (valido) break;
    end
    inicio = 1'b0;
    check("b2b_lat2", 64'(n), 64'(ANCHO + 2));
    check("b2b_bin2", 64'(binario), 64'd1);

    // Request during conversion must be dropped.
    convertir(16'h0500, 14'd500, 1'b0, 5, "ignorado");
    @(posedge clk); #1;
    check("ignorado_sin_cola", 64'(listo), 64'd1);

    // Asynchronous reset in the middle of a conversion.
    inicio      = 1'b1;
    bcd_entrada = 16'h4321;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_listo",   64'(listo),     64'd1);
    check("abort_valido",  64'(valido),    64'd0);
    check("abort_binario", 64'(binario),   64'd0);
    check("abort_error",   64'(error_bcd), 64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    vistos = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (valido) vistos++;
    end
    check("abort_sin_valido", 64'(vistos), 64'd0);
    convertir(16'h4321, 14'd4321, 1'b0, 0, "tras_reset");

    // Sampled sweep against a decimal reference.
    for (int v = 0; v < 10000; v += 97) begin
      bcd_v = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      convertir(bcd_v, 14'(v), 1'b0, 0, $sformatf("barrido%0d", v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
